wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Registered, parametrised write-back stage for the AURA16 pipeline: it replaces the purely combinational write-back selector with a one-entry commit buffer. It accepts retiring instructions from MEM, waits for variable-latency load data when needed, selects and extends the write-back value from one of four sources, and drives the register-file write port, forwarding bus, load-hazard flags and a retire counter.

## Interface
- DATA_W, 16: datapath width.
- RA_W, 3: register address width.
- SEL_W, 2: source-select width.
- CNT_W, 16: retire counter width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  MEM offers an instruction.
- in_ready  out  1  stage accepts this cycle; a transfer happens when in_valid && in_ready.
- in_reg_write  in  1  instruction writes the register file.
- in_rd  in  RA_W  destination register.
- in_sel  in  SEL_W  source: 0 ALU, 1 MEM, 2 PC+1 (JAL), 3 IMM (LUI); any other value selects ALU.
- in_ld_byte, in_ld_signed  in  1 each  byte load; sign-extend when signed, zero-extend otherwise. Ignored unless in_sel==1.
- in_alu, in_pc1, in_imm  in  DATA_W each  candidate values.
- mem_rdata  in  DATA_W  load data.
- mem_rvalid  in  1  load data valid.
- flush  in  1  kill an uncommitted entry and the incoming offer.
- rf_we  out  1; rf_waddr  out  RA_W; rf_wdata  out  DATA_W  register-file write port.
- fwd_valid  out  1; fwd_addr  out  RA_W; fwd_data  out  DATA_W  forwarding bus.
- ld_pending  out  1; ld_rd  out  RA_W  load waiting for data, and its destination.
- retire_cnt  out  CNT_W  committed-instruction count.

## Operation
- States: EMPTY, WAIT_MEM, COMMIT.
- in_ready = 1 in EMPTY and COMMIT, 0 in WAIT_MEM, and 0 while reset or flush is high.
- Accept with in_sel==1: latch all fields and go to WAIT_MEM.
- Accept with any other in_sel: compute the value, latch it and go to COMMIT.
- WAIT_MEM with mem_rvalid: capture mem_rdata; with in_ld_byte, use bits [7:0], extended per in_ld_signed. Go to COMMIT.
- WAIT_MEM without mem_rvalid: hold.
- COMMIT: rf_we = reg_write && rd!=0; rf_waddr/rf_wdata come from the entry; retire_cnt increments by 1, wrapping modulo 2^CNT_W.
  - The increment counts non-writing and rd==0 entries too.
  - Next state: COMMIT if a new accept occurs in the same cycle, else EMPTY.
- fwd_valid equals rf_we; fwd_addr and fwd_data equal rf_waddr and rf_wdata.
- ld_pending = (state==WAIT_MEM); ld_rd = latched rd. ld_rd is 0 when not pending.
- mem_rvalid outside WAIT_MEM is ignored, with no state change.
- flush:
  - In WAIT_MEM: discard the entry and go to EMPTY; no write, no count.
  - In COMMIT: the commit still completes; the offer is dropped; next state EMPTY.
  - flush has priority over mem_rvalid.
- Reset: state EMPTY. rf_we, rf_waddr, rf_wdata, fwd_*, ld_pending, ld_rd and retire_cnt are all 0. in_ready is 0 during reset and 1 in the first cycle after.
  - Reset mid-WAIT_MEM drops the entry with no write.

## Timing
- Non-load: accept at edge N; rf_we high in cycle N+1 (the cycle after edge N). Throughput is 1 per cycle.
- Load: mem_rvalid sampled at edge M; rf_we high in cycle M+1. The minimum accept-to-commit latency is 2 cycles.
- All outputs are registered or decoded from state only, with no combinational path from inputs. The exception is in_ready, which depends on flush and reset.
- ld_pending is high from the cycle after the load is accepted until the cycle its data is captured, inclusive.

## Structure
- Package wb_pkg holds:
  - SEL_ALU/SEL_MEM/SEL_PC1/SEL_IMM constants;
  - the state enum (EMPTY, WAIT_MEM, COMMIT);
  - a byte-extend function.
- One sub-module, wb_src_select: combinational source select plus byte extension, parametrised by DATA_W. It is instantiated twice, on the accept path and on the load-capture path.

## Test plan
- ALU stream: 3 back-to-back accepts (rd=1,2,3; alu=0x0011, 0x0022, 0x0033) -> rf_we high on 3 consecutive cycles with matching addr/data; retire_cnt=3; in_ready never drops.
- Byte loads: load rd=4 with ld_byte, ld_signed=1; mem_rvalid after 3 cycles, mem_rdata=0x12F0 -> ld_pending=1, ld_rd=4 for 3 cycles, then rf_wdata=0xFFF0; the same with signed=0 -> 0x00F0; in_ready=0 while waiting.
- JAL and LUI: JAL rd=7, sel=2, pc1=0x0040 -> rf_wdata=0x0040; LUI sel=3, imm=0xAB00 -> 0xAB00; ALU with rd=0 -> rf_we=0, fwd_valid=0, retire_cnt still increments.
- Flush during WAIT_MEM: flush the same cycle as mem_rvalid -> no write, state EMPTY, count unchanged. A stray mem_rvalid afterwards is ignored.
- Flush in COMMIT with in_valid high -> the commit completes and the offer is not accepted.
- Counter and reset: preload CNT_W=4 and retire 17 entries -> retire_cnt=1. Assert reset in WAIT_MEM -> all outputs 0 next cycle, then in_ready=1.

Source files
------------

// File: rtl/wb_commit_stage_pkg.sv
// -----------------------------------------------------------------------------
// wb_pkg: shared definitions for the AURA16 write-back commit stage.
//   SEL_* : write-back source encodings (any unlisted value falls back to ALU)
//   state_e : commit-buffer state
//   byte_ext: extends a load byte to EXT_W bits; callers truncate to DATA_W
// -----------------------------------------------------------------------------
package wb_pkg;

   localparam int SEL_ALU = 0;
   localparam int SEL_MEM = 1;
   localparam int SEL_PC1 = 2;
   localparam int SEL_IMM = 3;

   typedef enum logic [1:0] {
      S_EMPTY    = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_COMMIT   = 2'd2
   } state_e;

   // Wide enough for any sensible datapath; a package function cannot see
   // the instantiating module's DATA_W.
   localparam int EXT_W = 64;

   function automatic logic [EXT_W-1:0] byte_ext(input logic [7:0] b, input logic sgn);
      byte_ext = {{(EXT_W-8){sgn & b[7]}}, b};
   endfunction

endpackage

// File: rtl/wb_commit_stage_if.sv
// -----------------------------------------------------------------------------
// wb_commit_stage_if: bundle between MEM / load unit and the write-back stage.
//   MEM offer   : in_valid/in_ready handshake plus in_* instruction fields
//   load return : mem_rdata, mem_rvalid
//   control     : flush
//   results     : register-file write port, forwarding bus, load-hazard
//                 flags and retire counter
// master = producer side (MEM / bench), slave = wb_commit_stage.
// -----------------------------------------------------------------------------
interface wb_commit_stage_if #(
   parameter int DATA_W = 16,
   parameter int RA_W   = 3,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic              in_reg_write;
   logic [RA_W-1:0]   in_rd;
   logic [SEL_W-1:0]  in_sel;
   logic              in_ld_byte;
   logic              in_ld_signed;
   logic [DATA_W-1:0] in_alu;
   logic [DATA_W-1:0] in_pc1;
   logic [DATA_W-1:0] in_imm;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_rvalid;
   logic              flush;
   logic              rf_we;
   logic [RA_W-1:0]   rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              fwd_valid;
   logic [RA_W-1:0]   fwd_addr;
   logic [DATA_W-1:0] fwd_data;
   logic              ld_pending;
   logic [RA_W-1:0]   ld_rd;
   logic [CNT_W-1:0]  retire_cnt;

   modport master (
      output in_valid, in_reg_write, in_rd, in_sel, in_ld_byte, in_ld_signed,
             in_alu, in_pc1, in_imm, mem_rdata, mem_rvalid, flush,
      input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
             ld_pending, ld_rd, retire_cnt
   );

   modport slave (
      input  in_valid, in_reg_write, in_rd, in_sel, in_ld_byte, in_ld_signed,
             in_alu, in_pc1, in_imm, mem_rdata, mem_rvalid, flush,
      output in_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr, fwd_data,
             ld_pending, ld_rd, retire_cnt
   );
endinterface

// File: rtl/wb_commit_stage_src_select.sv
// -----------------------------------------------------------------------------
// wb_src_select: combinational write-back source mux with load-byte extension.
//   i_sel        : source select (SEL_ALU/MEM/PC1/IMM, others -> ALU)
//   i_ld_byte    : MEM source uses only bits [7:0]
//   i_ld_signed  : sign-extend the byte (else zero-extend)
//   i_alu/i_mem/i_pc1/i_imm : candidate values
//   o_val        : selected write-back value
// -----------------------------------------------------------------------------
module wb_src_select
   import wb_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int SEL_W  = 2
) (
   input  logic [SEL_W-1:0]  i_sel,
   input  logic              i_ld_byte,
   input  logic              i_ld_signed,
   input  logic [DATA_W-1:0] i_alu,
   input  logic [DATA_W-1:0] i_mem,
   input  logic [DATA_W-1:0] i_pc1,
   input  logic [DATA_W-1:0] i_imm,
   output logic [DATA_W-1:0] o_val
);

   always_comb begin
      o_val = i_alu;
      if (i_sel == SEL_W'(SEL_MEM))
         o_val = i_ld_byte ? DATA_W'(byte_ext(i_mem[7:0], i_ld_signed)) : i_mem;
      else if (i_sel == SEL_W'(SEL_PC1))
         o_val = i_pc1;
      else if (i_sel == SEL_W'(SEL_IMM))
         o_val = i_imm;
   end

endmodule

// File: rtl/wb_commit_stage.sv
// -----------------------------------------------------------------------------
// wb_commit_stage: one-entry registered write-back / commit buffer.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_commit_stage_if.slave (MEM offer, load return, flush,
//                register-file write, forwarding, load-hazard, retire count)
// Non-loads commit the cycle after acceptance; loads park in WAIT_MEM until
// mem_rvalid, then commit the following cycle. All outputs are decoded from
// registered state; only in_ready sees flush and reset combinationally.
// -----------------------------------------------------------------------------
module wb_commit_stage
   import wb_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int RA_W   = 3,
   parameter int SEL_W  = 2,
   parameter int CNT_W  = 16
) (
   input logic clk,
   input logic reset,
   wb_commit_stage_if.slave bus
);

   state_e            r_state, w_next;
   logic              r_we;
   logic [RA_W-1:0]   r_rd;
   logic              r_lb, r_ls;
   logic [DATA_W-1:0] r_data;
   logic [CNT_W-1:0]  r_cnt;

   logic              w_ready, w_acc, w_is_load, w_capture, w_commit, w_rf_we;
   logic [DATA_W-1:0] w_acc_val, w_ld_val;
   logic [RA_W-1:0]   w_waddr;
   logic [DATA_W-1:0] w_wdata;

   assign w_ready   = !reset && !bus.flush && (r_state != S_WAIT_MEM);
   assign w_acc     = bus.in_valid && w_ready;
   assign w_is_load = (bus.in_sel == SEL_W'(SEL_MEM));
   // flush wins over a same-cycle data return
   assign w_capture = (r_state == S_WAIT_MEM) && bus.mem_rvalid && !bus.flush;

   // Accept path: value for non-loads is final at acceptance.
   wb_src_select #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_sel_acc (
      .i_sel       (bus.in_sel),
      .i_ld_byte   (bus.in_ld_byte),
      .i_ld_signed (bus.in_ld_signed),
      .i_alu       (bus.in_alu),
      .i_mem       (bus.mem_rdata),
      .i_pc1       (bus.in_pc1),
      .i_imm       (bus.in_imm),
      .o_val       (w_acc_val)
   );

   // Load-capture path: forced to MEM, extension flags from the parked entry.
   wb_src_select #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_sel_ld (
      .i_sel       (SEL_W'(SEL_MEM)),
      .i_ld_byte   (r_lb),
      .i_ld_signed (r_ls),
      .i_alu       (bus.in_alu),
      .i_mem       (bus.mem_rdata),
      .i_pc1       (bus.in_pc1),
      .i_imm       (bus.in_imm),
      .o_val       (w_ld_val)
   );

   always_comb begin
      w_next   = r_state;
      w_commit = 1'b0;
      w_rf_we  = 1'b0;
      w_waddr  = '0;
      w_wdata  = '0;
      case (r_state)
         S_EMPTY: begin
            if (w_acc) w_next = w_is_load ? S_WAIT_MEM : S_COMMIT;
         end
         S_WAIT_MEM: begin
            if (bus.flush)           w_next = S_EMPTY;
            else if (bus.mem_rvalid) w_next = S_COMMIT;
         end
         S_COMMIT: begin
            w_commit = 1'b1;
            w_rf_we  = r_we && (r_rd != '0);
            w_waddr  = r_rd;
            w_wdata  = r_data;
            // back-to-back accept keeps the buffer full
            if (w_acc) w_next = w_is_load ? S_WAIT_MEM : S_COMMIT;
            else       w_next = S_EMPTY;
         end
         default: w_next = S_EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_EMPTY;
         r_we    <= 1'b0;
         r_rd    <= '0;
         r_lb    <= 1'b0;
         r_ls    <= 1'b0;
         r_data  <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         if (w_commit) r_cnt <= r_cnt + CNT_W'(1);
         if (w_acc) begin
            r_we   <= bus.in_reg_write;
            r_rd   <= bus.in_rd;
            r_lb   <= bus.in_ld_byte;
            r_ls   <= bus.in_ld_signed;
            r_data <= w_acc_val;
         end else if (w_capture) begin
            r_data <= w_ld_val;
         end
      end
   end

   assign bus.in_ready   = w_ready;
   assign bus.rf_we      = w_rf_we;
   assign bus.rf_waddr   = w_waddr;
   assign bus.rf_wdata   = w_wdata;
   assign bus.fwd_valid  = w_rf_we;
   assign bus.fwd_addr   = w_waddr;
   assign bus.fwd_data   = w_wdata;
   assign bus.ld_pending = (r_state == S_WAIT_MEM);
   assign bus.ld_rd      = (r_state == S_WAIT_MEM) ? r_rd : '0;
   assign bus.retire_cnt = r_cnt;

endmodule

// File: tb/tb_wb_commit_stage.sv
// Bench for wb_commit_stage: directed vector table, hand-written corner
// sequences and a randomized phase, all checked against a behavioural
// model of the one-entry commit buffer.
module tb_wb_commit_stage;
   localparam int DW = 16, AW = 3, SW = 2, CW = 4;

   logic clk = 1'b0;
   logic reset;
   always #10 clk = ~clk;

   wb_commit_stage_if #(.DATA_W(DW), .RA_W(AW), .SEL_W(SW), .CNT_W(CW)) bus ();

   wb_commit_stage #(.DATA_W(DW), .RA_W(AW), .SEL_W(SW), .CNT_W(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk = 0, n_err = 0;

   // behavioural model: "is there an entry, is it still waiting for data"
   bit          m_have, m_wait, m_we, m_lb, m_ls;
   int          m_rd, m_cnt;
   logic [15:0] m_val;

   typedef struct {
      bit v, we; int rd, sel; bit lb, ls;
      logic [15:0] alu, pc1, imm, mrd; bit mrv, fl;
      bit e_rdy, e_we; int e_addr; logic [15:0] e_data; bit e_pend; int e_ldrd;
   } vec_t;
   vec_t vec [17];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] ext_load(input logic [15:0] d, input bit lb, input bit ls);
      int b;
      if (!lb) return d;
      b = int'(d) % 256;
      if (ls && b >= 128) return 16'(b - 256);
      return 16'(b);
   endfunction

   function automatic logic [15:0] pick(input int sel, input logic [15:0] alu, pc1, imm);
      if (sel == 2) return pc1;
      if (sel == 3) return imm;
      return alu;
   endfunction

   task automatic drv(input bit v, we, input int rd, sel, input bit lb, ls,
                      input logic [15:0] alu, pc1, imm, mrd, input bit mrv, fl);
      bus.in_valid = v; bus.in_reg_write = we; bus.in_rd = AW'(rd); bus.in_sel = SW'(sel);
      bus.in_ld_byte = lb; bus.in_ld_signed = ls;
      bus.in_alu = alu; bus.in_pc1 = pc1; bus.in_imm = imm;
      bus.mem_rdata = mrd; bus.mem_rvalid = mrv; bus.flush = fl;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic model_clear();
      m_have = 0; m_wait = 0; m_we = 0; m_lb = 0; m_ls = 0; m_rd = 0; m_cnt = 0; m_val = 0;
   endtask

   // Check current-cycle outputs against the model, advance the model with the
   // applied inputs, then cross the clock edge.
   task automatic tick();
      bit commit, pend, we, rdy, acc;
      #2;
      commit = m_have && !m_wait;
      pend   = m_have && m_wait;
      we     = commit && m_we && (m_rd != 0);
      rdy    = !reset && !bus.flush && !pend;
      chk("in_ready",   bus.in_ready,   rdy);
      chk("rf_we",      bus.rf_we,      we);
      chk("fwd_valid",  bus.fwd_valid,  we);
      chk("ld_pending", bus.ld_pending, pend);
      chk("ld_rd",      bus.ld_rd,      pend ? m_rd : 0);
      chk("retire_cnt", bus.retire_cnt, m_cnt);
      if (commit) begin
         chk("rf_waddr", bus.rf_waddr, m_rd);
         chk("rf_wdata", bus.rf_wdata, m_val);
         chk("fwd_addr", bus.fwd_addr, m_rd);
         chk("fwd_data", bus.fwd_data, m_val);
      end
      if (reset) model_clear();
      else begin
         acc = bus.in_valid && rdy;
         if (commit) begin m_cnt = (m_cnt + 1) % (1 << CW); m_have = 0; end
         if (pend) begin
            if (bus.flush) m_have = 0;
            else if (bus.mem_rvalid) begin
               m_val = ext_load(bus.mem_rdata, m_lb, m_ls); m_wait = 0;
            end
         end
         if (acc) begin
            m_have = 1; m_we = bus.in_reg_write; m_rd = int'(bus.in_rd);
            m_lb = bus.in_ld_byte; m_ls = bus.in_ld_signed;
            m_wait = (bus.in_sel == 2'd1);
            if (!m_wait) m_val = pick(int'(bus.in_sel), bus.in_alu, bus.in_pc1, bus.in_imm);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      //            v we rd sel lb ls alu      pc1      imm      mrd      mrv fl  rdy we addr data     pend ldrd
      vec[0]  = '{1, 1, 1, 0, 0, 0, 'h0011, 0,       0,       0,       0, 0,  1, 0, 0, 0,       0, 0};
      vec[1]  = '{1, 1, 2, 0, 0, 0, 'h0022, 0,       0,       0,       0, 0,  1, 1, 1, 'h0011,  0, 0};
      vec[2]  = '{1, 1, 3, 0, 0, 0, 'h0033, 0,       0,       0,       0, 0,  1, 1, 2, 'h0022,  0, 0};
      vec[3]  = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  1, 1, 3, 'h0033,  0, 0};
      vec[4]  = '{1, 1, 4, 1, 1, 1, 0,      0,       0,       0,       0, 0,  1, 0, 0, 0,       0, 0};
      vec[5]  = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  0, 0, 0, 0,       1, 4};
      vec[6]  = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  0, 0, 0, 0,       1, 4};
      vec[7]  = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       'h12F0,  1, 0,  0, 0, 0, 0,       1, 4};
      vec[8]  = '{1, 1, 4, 1, 1, 0, 0,      0,       0,       0,       0, 0,  1, 1, 4, 'hFFF0,  0, 0};
      vec[9]  = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  0, 0, 0, 0,       1, 4};
      vec[10] = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  0, 0, 0, 0,       1, 4};
      vec[11] = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       'h12F0,  1, 0,  0, 0, 0, 0,       1, 4};
      vec[12] = '{1, 1, 7, 2, 0, 0, 0,      'h0040,  0,       0,       0, 0,  1, 1, 4, 'h00F0,  0, 0};
      vec[13] = '{1, 1, 5, 3, 0, 0, 0,      0,       'hAB00,  0,       0, 0,  1, 1, 7, 'h0040,  0, 0};
      vec[14] = '{1, 1, 0, 0, 0, 0, 'h5555, 0,       0,       0,       0, 0,  1, 1, 5, 'hAB00,  0, 0};
      vec[15] = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  1, 0, 0, 0,       0, 0};
      vec[16] = '{0, 0, 0, 0, 0, 0, 0,      0,       0,       0,       0, 0,  1, 0, 0, 0,       0, 0};

      model_clear();
      reset = 1'b1;
      idle();
      @(posedge clk); #1;
      tick();                      // still in reset: in_ready low, outputs zero
      reset = 1'b0;
      chk("rst_waddr", bus.rf_waddr, 0);
      chk("rst_wdata", bus.rf_wdata, 0);
      tick();                      // first cycle out of reset: in_ready high

      // directed vectors: ALU stream, byte loads, JAL/LUI, rd==0
      for (int i = 0; i < 17; i++) begin
         drv(vec[i].v, vec[i].we, vec[i].rd, vec[i].sel, vec[i].lb, vec[i].ls,
             vec[i].alu, vec[i].pc1, vec[i].imm, vec[i].mrd, vec[i].mrv, vec[i].fl);
         #2;
         chk($sformatf("vec%0d_ready", i), bus.in_ready, vec[i].e_rdy);
         chk($sformatf("vec%0d_we", i), bus.rf_we, vec[i].e_we);
         chk($sformatf("vec%0d_fwdv", i), bus.fwd_valid, vec[i].e_we);
         chk($sformatf("vec%0d_pend", i), bus.ld_pending, vec[i].e_pend);
         chk($sformatf("vec%0d_ldrd", i), bus.ld_rd, vec[i].e_ldrd);
         if (vec[i].e_we) begin
            chk($sformatf("vec%0d_addr", i), bus.rf_waddr, vec[i].e_addr);
            chk($sformatf("vec%0d_data", i), bus.rf_wdata, vec[i].e_data);
            chk($sformatf("vec%0d_fdata", i), bus.fwd_data, vec[i].e_data);
         end
         tick();
      end
      chk("cnt_after_vectors", bus.retire_cnt, 8);

      // flush in WAIT_MEM together with mem_rvalid, then a stray mem_rvalid
      drv(1, 1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      idle(); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h1234, 1, 1); tick();
      idle(); chk("flushwm_empty_pend", bus.ld_pending, 0); tick();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 'h4321, 1, 0); tick();
      idle(); tick();
      chk("flushwm_cnt", bus.retire_cnt, 8);
      chk("flushwm_no_we", bus.rf_we, 0);

      // flush in COMMIT with an offer present: commit completes, offer dropped
      drv(1, 1, 2, 0, 0, 0, 'h0777, 0, 0, 0, 0, 0); tick();
      drv(1, 1, 3, 0, 0, 0, 'h0888, 0, 0, 0, 0, 1);
      #1; chk("flushc_ready", bus.in_ready, 0);
      chk("flushc_data", bus.rf_wdata, 'h0777);
      tick();
      idle(); chk("flushc_dropped", bus.rf_we, 0); tick();
      chk("flushc_cnt", bus.retire_cnt, 9);

      // reset while a load is waiting: entry dropped, everything zero
      drv(1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0); tick();
      idle(); reset = 1'b1; tick();
      reset = 1'b0;
      chk("rstwm_pend", bus.ld_pending, 0);
      chk("rstwm_ldrd", bus.ld_rd, 0);
      chk("rstwm_we", bus.rf_we, 0);
      chk("rstwm_cnt", bus.retire_cnt, 0);
      chk("rstwm_fdata", bus.fwd_data, 0);
      tick();

      // counter wrap: 17 retirements with a 4-bit counter
      for (int i = 0; i < 17; i++) begin
         drv(1, i[0], (i % 7) + 1, 0, 0, 0, 16'(i), 0, 0, 0, 0, 0); tick();
      end
      idle(); tick();
      chk("cnt_wrap", bus.retire_cnt, 1);

      // randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         drv($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
             $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
             $urandom_range(0, 2) == 0, $urandom_range(0, 11) == 0);
         reset = ($urandom_range(0, 59) == 0);
         tick();
      end
      reset = 1'b0;
      idle(); tick(); tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, got running want done");
      $fatal(1);
   end

endmodule
